// File: rtl/mult_scheduler.sv
// Round-robin front end for one shared multiplier: grants a core, forwards its
// operands as a single-cycle start, and routes the product and a done pulse back.
module mult_scheduler #(
    parameter int NumPorts  = 4,
    parameter int DataWidth = 8,
    parameter int MaxBurst  = 4,
    parameter int SelWidth  = (NumPorts > 1) ? $clog2(NumPorts) : 1
) (
    input  logic                          clk_i,
    input  logic                          reset_i,
    input  logic [NumPorts-1:0]           req_i,
    output logic [NumPorts-1:0]           grant_o,
    input  logic [NumPorts-1:0]           start_i,
    input  logic [NumPorts*DataWidth-1:0] a_i,
    input  logic [NumPorts*DataWidth-1:0] b_i,
    output logic [DataWidth-1:0]          result_o,
    output logic                          ovfl_o,
    output logic [NumPorts-1:0]           done_o,
    output logic [SelWidth-1:0]           select_o,
    output logic                          active_o,
    output logic                          mul_start_o,
    output logic [DataWidth-1:0]          mul_a_o,
    output logic [DataWidth-1:0]          mul_b_o,
    input  logic                          mul_busy_i,
    input  logic                          mul_done_i,
    input  logic                          mul_valid_i,
    input  logic                          mul_ovf_i,
    input  logic [DataWidth-1:0]          mul_val_i
);

    localparam int              CntW     = (MaxBurst > 0) ? $clog2(MaxBurst + 1) : 1;
    localparam logic [CntW-1:0] BurstLim = CntW'(MaxBurst);
    localparam bit              Limited  = (MaxBurst != 0);

    typedef enum logic [1:0] {IDLE, GRANT, WAIT} state_e;

    state_e                         state_q, state_d;
    logic [SelWidth-1:0]            sel_q, sel_d, last_q, last_d;
    logic [NumPorts-1:0]            grant_q, grant_d, done_q, done_d;
    logic                           active_q, active_d, pend_q, pend_d;
    logic                           mstart_q, mstart_d, ovfl_q, ovfl_d;
    logic [CntW-1:0]                cnt_q, cnt_d;
    logic [DataWidth-1:0]           ma_q, ma_d, mb_q, mb_d, res_q, res_d;

    logic [NumPorts-1:0][DataWidth-1:0] a_arr, b_arr;
    assign a_arr = a_i;
    assign b_arr = b_i;

    // Search starts just after the previous owner, so the last owner has lowest priority.
    logic [SelWidth-1:0] pick, idx;
    logic                any_req;
    always_comb begin
        pick    = '0;
        idx     = '0;
        any_req = 1'b0;
        for (int i = 1; i <= NumPorts; i++) begin
            idx = SelWidth'((int'(last_q) + i) % NumPorts);
            if (!any_req && req_i[idx]) begin
                any_req = 1'b1;
                pick    = idx;
            end
        end
    end

    logic start_hit, pend_any, go, others, release_now;
    assign start_hit   = start_i[sel_q];
    assign pend_any    = pend_q | start_hit;
    assign go          = pend_any & ~mul_busy_i;
    assign others      = |(req_i & ~grant_q);
    assign release_now = ~pend_any &
                         (~req_i[sel_q] | (Limited && cnt_q == BurstLim && others));

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            state_q  <= IDLE;
            sel_q    <= '0;
            last_q   <= SelWidth'(NumPorts - 1);
            grant_q  <= '0;
            done_q   <= '0;
            active_q <= 1'b0;
            pend_q   <= 1'b0;
            mstart_q <= 1'b0;
            ovfl_q   <= 1'b0;
            cnt_q    <= '0;
            ma_q     <= '0;
            mb_q     <= '0;
            res_q    <= '0;
        end else begin
            state_q  <= state_d;
            sel_q    <= sel_d;
            last_q   <= last_d;
            grant_q  <= grant_d;
            done_q   <= done_d;
            active_q <= active_d;
            pend_q   <= pend_d;
            mstart_q <= mstart_d;
            ovfl_q   <= ovfl_d;
            cnt_q    <= cnt_d;
            ma_q     <= ma_d;
            mb_q     <= mb_d;
            res_q    <= res_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:  if (any_req) state_d = GRANT;
            GRANT: begin
                if (go)               state_d = WAIT;
                else if (release_now) state_d = IDLE;
            end
            WAIT:  if (mul_done_i) state_d = GRANT;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        sel_d    = sel_q;
        last_d   = last_q;
        grant_d  = grant_q;
        done_d   = '0;
        active_d = active_q;
        pend_d   = pend_q;
        mstart_d = 1'b0;
        ovfl_d   = ovfl_q;
        cnt_d    = cnt_q;
        ma_d     = ma_q;
        mb_d     = mb_q;
        res_d    = res_q;
        unique case (state_q)
            IDLE: if (any_req) begin
                sel_d    = pick;
                grant_d  = NumPorts'(1) << pick;
                active_d = 1'b1;
                cnt_d    = '0;
                pend_d   = 1'b0;
            end
            GRANT: begin
                if (go) begin
                    ma_d     = a_arr[sel_q];
                    mb_d     = b_arr[sel_q];
                    mstart_d = 1'b1;
                    pend_d   = 1'b0;
                    // Saturate so a lone requester never wraps back under the limit.
                    if (!Limited || cnt_q != BurstLim) cnt_d = cnt_q + CntW'(1);
                end else if (start_hit) begin
                    pend_d = 1'b1;
                end else if (release_now) begin
                    grant_d  = '0;
                    active_d = 1'b0;
                    last_d   = sel_q;
                end
            end
            WAIT: if (mul_done_i) begin
                res_d  = mul_val_i;
                ovfl_d = mul_ovf_i | ~mul_valid_i;
                done_d = grant_q;
            end
            default: ;
        endcase
    end

    assign grant_o     = grant_q;
    assign done_o      = done_q;
    assign select_o    = sel_q;
    assign active_o    = active_q;
    assign mul_start_o = mstart_q;
    assign mul_a_o     = ma_q;
    assign mul_b_o     = mb_q;
    assign result_o    = res_q;
    assign ovfl_o      = ovfl_q;

endmodule

// File: tb/tb_mult_scheduler.sv
// Directed scenarios plus a randomized run against a transaction-level model
// of arbitration order and product routing.
module tb_mult_scheduler;
    localparam int NP = 4;
    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          reset_i;
    logic [NP-1:0] req, start;
    logic [DW-1:0] a_op [NP];
    logic [DW-1:0] b_op [NP];
    logic [NP*DW-1:0] a_flat, b_flat;
    logic [NP-1:0] grant_o, done_o;
    logic [DW-1:0] result_o, mul_a_o, mul_b_o;
    logic          ovfl_o, active_o, mul_start_o;
    logic [1:0]    select_o;
    logic          mbusy, mdone, mvalid, movf;
    logic [DW-1:0] mval;

    assign a_flat = {a_op[3], a_op[2], a_op[1], a_op[0]};
    assign b_flat = {b_op[3], b_op[2], b_op[1], b_op[0]};

    always #5 clk = ~clk;

    mult_scheduler #(.NumPorts(NP), .DataWidth(DW), .MaxBurst(2)) dut (
        .clk_i(clk), .reset_i(reset_i), .req_i(req), .grant_o(grant_o),
        .start_i(start), .a_i(a_flat), .b_i(b_flat), .result_o(result_o),
        .ovfl_o(ovfl_o), .done_o(done_o), .select_o(select_o), .active_o(active_o),
        .mul_start_o(mul_start_o), .mul_a_o(mul_a_o), .mul_b_o(mul_b_o),
        .mul_busy_i(mbusy), .mul_done_i(mdone), .mul_valid_i(mvalid),
        .mul_ovf_i(movf), .mul_val_i(mval)
    );

    int total = 0;
    int bad   = 0;
    bit auto_mul = 0;
    int mcnt = 0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%0h exp=%0h", tag, act, exp);
        end
    endtask

    // Behavioural multiplier: busy for a random latency, then a done pulse.
    task automatic step();
        @(posedge clk);
        #1;
        if (auto_mul) begin
            mdone = 1'b0;
            if (mul_start_o) begin
                logic [15:0] p;
                p      = mul_a_o * mul_b_o;
                mbusy  = 1'b1;
                mcnt   = $urandom_range(0, 3);
                mval   = p[7:0];
                movf   = (p[15:8] != 0);
                mvalid = 1'b1;
            end else if (mbusy) begin
                if (mcnt == 0) begin
                    mdone = 1'b1;
                    mbusy = 1'b0;
                end else mcnt--;
            end
        end
    endtask

    task automatic do_reset(input bit am);
        reset_i = 1'b0;
        req = '0; start = '0;
        for (int i = 0; i < NP; i++) begin a_op[i] = '0; b_op[i] = '0; end
        mbusy = 0; mdone = 0; mvalid = 1; movf = 0; mval = '0; mcnt = 0;
        auto_mul = am;
        step(); step();
        reset_i = 1'b1;
    endtask

    task automatic do_op(input int p, input logic [7:0] av, input logic [7:0] bv);
        logic [15:0] prod;
        bit seen;
        prod = av * bv;
        a_op[p] = av; b_op[p] = bv; start[p] = 1'b1;
        step();
        start[p] = 1'b0;
        seen = 0;
        for (int k = 0; k < 20 && !seen; k++) begin
            step();
            if (done_o != 0) seen = 1;
        end
        chk("op_timeout", 32'(seen), 1);
        chk("op_done", done_o, 32'(1 << p));
        chk("op_res", result_o, prod[7:0]);
        chk("op_ovf", ovfl_o, 32'(prod[15:8] != 0));
    endtask

    function automatic int rr_pick(input logic [NP-1:0] r, input int last);
        for (int i = 1; i <= NP; i++)
            if (r[(last + i) % NP]) return (last + i) % NP;
        return -1;
    endfunction

    function automatic int owner(input logic [NP-1:0] g);
        for (int i = 0; i < NP; i++) if (g[i]) return i;
        return 0;
    endfunction

    initial begin
        // 1: single request, full op
        reset_i = 1'b0;
        do_reset(0);
        chk("reset_outs", {grant_o, done_o, result_o, ovfl_o, select_o, active_o,
                           mul_start_o, mul_a_o, mul_b_o}, 0);
        req = 4'b0100;
        step();
        chk("t1_grant", grant_o, 4'b0100);
        chk("t1_sel", select_o, 2);
        chk("t1_active", active_o, 1);
        a_op[2] = 8'h18; b_op[2] = 8'h20; start[2] = 1'b1;
        step();
        start = '0;
        chk("t1_mstart", mul_start_o, 1);
        chk("t1_ma", mul_a_o, 8'h18);
        chk("t1_mb", mul_b_o, 8'h20);
        mdone = 1; mval = 8'h30; mvalid = 1; movf = 0;
        step();
        mdone = 0;
        chk("t1_mstart_pulse", mul_start_o, 0);
        chk("t1_done", done_o, 4'b0100);
        chk("t1_res", result_o, 8'h30);
        chk("t1_ovf", ovfl_o, 0);
        step();
        chk("t1_done_pulse", done_o, 0);

        // 2: everyone requests, one op each, rotating grants with an idle gap
        do_reset(1);
        req = 4'b1111;
        step();
        for (int p = 0; p < NP; p++) begin
            chk("t2_grant", grant_o, 32'(1 << p));
            do_op(p, 8'(p + 3), 8'(p * 7 + 1));
            req[p] = 1'b0;
            step();
            chk("t2_gap", grant_o, 0);
            step();
        end
        chk("t2_end", grant_o, 0);

        // 3: burst limit with a competitor, then without
        do_reset(1);
        req = 4'b0011;
        step();
        chk("t3_grant0", grant_o, 4'b0001);
        do_op(0, 8'h11, 8'h22);
        do_op(0, 8'hF0, 8'h10);
        step();
        chk("t3_release", grant_o, 0);
        step();
        chk("t3_grant1", grant_o, 4'b0010);
        do_reset(1);
        req = 4'b0001;
        step();
        for (int k = 0; k < 3; k++) do_op(0, 8'(k + 2), 8'h05);
        step(); step();
        chk("t3_keep", grant_o, 4'b0001);

        // 4: busy multiplier defers issue; foreign start is ignored
        do_reset(0);
        req = 4'b0010;
        step();
        chk("t4_grant", grant_o, 4'b0010);
        mbusy = 1; a_op[1] = 8'h05; b_op[1] = 8'h07; start = 4'b1010;
        step();
        start = '0;
        chk("t4_nostart0", mul_start_o, 0);
        for (int k = 0; k < 4; k++) begin
            step();
            chk("t4_nostart", mul_start_o, 0);
        end
        mbusy = 0;
        step();
        chk("t4_start", mul_start_o, 1);
        chk("t4_ma", mul_a_o, 8'h05);
        mdone = 1; mval = 8'h23; mvalid = 0; movf = 0;
        step();
        mdone = 0; mvalid = 1;
        chk("t4_done", done_o, 4'b0010);
        chk("t4_invalid_ovf", ovfl_o, 1);
        start[3] = 1'b1;
        step();
        start = '0;
        chk("t4_foreign", mul_start_o, 0);
        step();
        chk("t4_foreign2", mul_start_o, 0);

        // 5: reset during WAIT, stale done afterwards
        do_reset(0);
        req = 4'b0100;
        step();
        start[2] = 1'b1; a_op[2] = 8'h09; b_op[2] = 8'h09;
        step();
        start = '0;
        chk("t5_inflight", mul_start_o, 1);
        reset_i = 1'b0;
        #1;
        chk("t5_async", {grant_o, active_o, mul_start_o, mul_a_o}, 0);
        step();
        reset_i = 1'b1; req = '0;
        mdone = 1; mval = 8'h55; movf = 1;
        step();
        mdone = 0; movf = 0;
        chk("t5_stale", {done_o, result_o, ovfl_o, grant_o, active_o}, 0);
        req = 4'b1111;
        step();
        chk("t5_ptr", grant_o, 4'b0001);

        // 6: owner drops req while in WAIT
        do_reset(0);
        req = 4'b0010;
        step();
        start[1] = 1'b1; a_op[1] = 8'h10; b_op[1] = 8'h10;
        step();
        start = '0; req = '0;
        step();
        mdone = 1; mval = 8'h7F; movf = 1; mvalid = 1;
        step();
        mdone = 0; movf = 0;
        chk("t6_done", done_o, 4'b0010);
        chk("t6_res", result_o, 8'h7F);
        chk("t6_ovf", ovfl_o, 1);
        chk("t6_held", grant_o, 4'b0010);
        step();
        chk("t6_release", grant_o, 0);

        // Randomized traffic
        begin
            bit          want [NP];
            bit          outst [NP];
            int          left [NP];
            logic [7:0]  ea [NP];
            logic [7:0]  eb [NP];
            int          last_owner = NP - 1;
            int          dones = 0;
            logic [NP-1:0] req_edge, prev_g;
            logic        busy_edge;
            logic [15:0] prod;
            do_reset(1);
            for (int i = 0; i < NP; i++) begin
                want[i] = 0; outst[i] = 0; left[i] = 0; ea[i] = 0; eb[i] = 0;
            end
            for (int cyc = 0; cyc < 3000; cyc++) begin
                req_edge  = req;
                busy_edge = mbusy;
                prev_g    = grant_o;
                step();
                chk("r_onehot", 32'($onehot0(grant_o)), 1);
                if (mul_start_o) begin
                    chk("r_start_busy", busy_edge, 0);
                    chk("r_ma", mul_a_o, ea[owner(grant_o)]);
                    chk("r_mb", mul_b_o, eb[owner(grant_o)]);
                end
                if (prev_g == 0 && grant_o != 0)
                    chk("r_rr", grant_o, 32'(1 << rr_pick(req_edge, last_owner)));
                if (prev_g != 0 && grant_o == 0)
                    last_owner = owner(prev_g);
                if (done_o != 0) begin
                    int p;
                    p = owner(done_o);
                    prod = ea[p] * eb[p];
                    chk("r_done_owner", done_o, grant_o);
                    chk("r_outst", 32'(outst[p]), 1);
                    chk("r_res", result_o, prod[7:0]);
                    chk("r_ovf", ovfl_o, 32'(prod[15:8] != 0));
                    outst[p] = 0;
                    left[p]--;
                    dones++;
                end
                start = '0;
                for (int p = 0; p < NP; p++) begin
                    if (want[p] && left[p] <= 0 && !outst[p]) want[p] = 0;
                    else if (!want[p] && $urandom_range(0, 7) == 0) begin
                        want[p] = 1;
                        left[p] = $urandom_range(1, 4);
                    end
                    if (!grant_o[p] && $urandom_range(0, 3) == 0) start[p] = 1'b1;
                end
                if (grant_o != 0) begin
                    int p;
                    p = owner(grant_o);
                    start[p] = 1'b0;
                    if (want[p] && !outst[p] && $urandom_range(0, 1) == 1) begin
                        ea[p] = 8'($urandom); eb[p] = 8'($urandom);
                        a_op[p] = ea[p]; b_op[p] = eb[p];
                        start[p] = 1'b1;
                        outst[p] = 1;
                    end
                end
                for (int p = 0; p < NP; p++) req[p] = want[p];
            end
            chk("r_progress", 32'(dones > 50), 1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
